// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for a registered two-operand ALU with a 4x8 register file.
// Optional zero_flag output is enabled by defining ALU_ZERO_FLAG_EN.
module alu_issue_ctrl #(
   parameter int ALU_LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] instr_data,
   input  logic       instr_valid,
   output logic       instr_ready,
   output logic [7:0] alu_op,
   output logic [7:0] alu_in1,
   output logic [7:0] alu_in2,
   input  logic [7:0] alu_result,
   output logic       busy,
   output logic       wb_valid,
   output logic [1:0] wb_addr,
   output logic [7:0] wb_data,
   input  logic [1:0] reg_rd_sel,
   output logic [7:0] reg_rd_data,
   output logic [1:0] dbg_state
`ifdef ALU_ZERO_FLAG_EN
   ,
   output logic       zero_flag
`endif
);

   // Handshake: a byte transfers on a rising edge where instr_valid && instr_ready;
   // instr_ready depends only on state (FETCH/IMM) and is held low during reset.

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_IMM   = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   localparam logic [2:0] LAT = 3'(ALU_LATENCY);
   localparam logic [1:0] OPC_ADD = 2'b01;
   localparam logic [1:0] OPC_SUB = 2'b10;
   localparam logic [1:0] OPC_LDI = 2'b11;

   state_t     r_state;
   state_t     w_next_state;
   logic [7:0] r_regs [4];
   logic [7:0] r_alu_op;
   logic [7:0] r_alu_in1;
   logic [7:0] r_alu_in2;
   logic [2:0] r_cnt;
   logic [1:0] r_rd;
   logic       r_wb_valid;
   logic [1:0] r_wb_addr;
   logic [7:0] r_wb_data;

   logic       w_xfer;
   logic [1:0] w_opc;
   logic       w_issue;
   logic       w_imm_wr;
   logic       w_alu_wr;
   logic       w_wb_en;
   logic [7:0] w_wb_val;

   assign instr_ready = rst_n && ((r_state == S_FETCH) || (r_state == S_IMM));
   assign w_xfer      = instr_valid && instr_ready;
   assign w_opc       = instr_data[7:6];

   assign w_issue  = (r_state == S_FETCH) && w_xfer && ((w_opc == OPC_ADD) || (w_opc == OPC_SUB));
   assign w_imm_wr = (r_state == S_IMM) && w_xfer;
   assign w_alu_wr = (r_state == S_WAIT) && (r_cnt == 3'd0);
   assign w_wb_en  = w_imm_wr || w_alu_wr;
   assign w_wb_val = w_imm_wr ? instr_data : alu_result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FETCH;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FETCH: begin
            if (w_xfer) begin
               if (w_opc == OPC_LDI)                           w_next_state = S_IMM;
               else if ((w_opc == OPC_ADD) || (w_opc == OPC_SUB)) w_next_state = S_WAIT;
            end
         end
         S_IMM:   if (w_xfer) w_next_state = S_FETCH;
         S_WAIT:  if (r_cnt == 3'd0) w_next_state = S_FETCH;
         default: w_next_state = S_FETCH;
      endcase
   end

   // Operands are sampled at acceptance, so rd aliasing rs1/rs2 is harmless.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_regs[i] <= 8'h00;
         r_alu_op   <= 8'h00;
         r_alu_in1  <= 8'h00;
         r_alu_in2  <= 8'h00;
         r_cnt      <= 3'd0;
         r_rd       <= 2'd0;
         r_wb_valid <= 1'b0;
         r_wb_addr  <= 2'd0;
         r_wb_data  <= 8'h00;
      end else begin
         r_wb_valid <= w_wb_en;
         if (w_wb_en) begin
            r_regs[r_rd] <= w_wb_val;
            r_wb_addr    <= r_rd;
            r_wb_data    <= w_wb_val;
         end
         if ((r_state == S_FETCH) && w_xfer && (w_opc != 2'b00))
            r_rd <= instr_data[5:4];
         if (w_issue) begin
            r_alu_op  <= (w_opc == OPC_ADD) ? 8'h01 : 8'h02;
            r_alu_in1 <= r_regs[instr_data[3:2]];
            r_alu_in2 <= r_regs[instr_data[1:0]];
            r_cnt     <= LAT;
         end else if (r_state == S_WAIT) begin
            if (r_cnt == 3'd0) r_alu_op <= 8'h00;
            else               r_cnt    <= r_cnt - 3'd1;
         end
      end
   end

`ifdef ALU_ZERO_FLAG_EN
   logic r_zero;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_zero <= 1'b0;
      else if (w_alu_wr) r_zero <= (alu_result == 8'h00);
   end
   assign zero_flag = r_zero;
`endif

   assign alu_op      = r_alu_op;
   assign alu_in1     = r_alu_in1;
   assign alu_in2     = r_alu_in2;
   assign busy        = (r_state != S_FETCH);
   assign wb_valid    = r_wb_valid;
   assign wb_addr     = r_wb_addr;
   assign wb_data     = r_wb_data;
   assign reg_rd_data = r_regs[reg_rd_sel];
   assign dbg_state   = r_state;

endmodule
